// File: rtl/inst_fetch_resp_pkg.sv
// Shared definitions for the instruction fetch responder: bus widths,
// fixed instruction constants and the fetch FSM state encoding.
package inst_fetch_resp_pkg;

   localparam int          INST_ADDR_BUS = 32;
   localparam int          INST_BUS      = 32;
   localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
   localparam logic        CHIP_ENABLE   = 1'b1;
   localparam logic        CHIP_DISABLE  = 1'b0;
   // sll $0,$0,0 -- the canonical no-op word
   localparam logic [31:0] NOP_INST      = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH_IDLE = 2'd0,   // nothing outstanding
      FETCH_WAIT = 2'd1,   // one granted request, response pending
      FETCH_DROP = 2'd2    // granted before a flush, response is discarded
   } fetch_state_t;

endpackage

// File: rtl/inst_fetch_resp_fetch_fifo.sv
// Two-entry synchronous FIFO holding fetched {pc, inst[, exc]} entries.
// Clear has priority over push and pop. The head reads as zero when empty.
module fetch_fifo #(
   parameter int ENTRY_W = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  logic [ENTRY_W-1:0] push_data,
   input  logic               pop,
   input  logic               clear,
   output logic               full,
   output logic               empty,
   output logic [1:0]         count,
   output logic [ENTRY_W-1:0] head
);

   logic       rd_ptr_q, rd_ptr_d;
   logic       wr_ptr_q, wr_ptr_d;
   logic [1:0] count_q, count_d;
   logic       do_push, do_pop;

   // Pointer and occupancy update; a push into a full FIFO is only taken with a pop.
   always_comb begin
      do_pop   = pop & (count_q != 2'd0);
      do_push  = push & ((count_q != 2'd2) | do_pop);
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (clear) begin
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (do_push) wr_ptr_d = ~wr_ptr_q;
         if (do_pop)  rd_ptr_d = ~rd_ptr_q;
         count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   // Pointer and count registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_entry
         logic [ENTRY_W-1:0] entry_q, entry_d;

         // Write this slot when it is the push target.
         always_comb begin
            entry_d = entry_q;
            if (!clear && do_push && (wr_ptr_q == 1'(gi))) entry_d = push_data;
         end

         // Slot storage.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) entry_q <= '0;
            else      entry_q <= entry_d;
         end
      end
   endgenerate

   assign full  = (count_q == 2'd2);
   assign empty = (count_q == 2'd0);
   assign count = count_q;
   assign head  = empty ? '0 : (rd_ptr_q ? g_entry[1].entry_q : g_entry[0].entry_q);

endmodule

// File: rtl/inst_fetch_resp.sv
// Instruction fetch responder: accepts pc/ce from the PC stage, fetches via a
// req/gnt/rvalid memory port (one outstanding request), buffers results in a
// 2-entry FIFO for IF/ID and raises stallreq while the current pc is not taken.
// Optional build macro FETCH_ALIGN_CHECK_EN: misaligned pcs bypass memory and
// deliver a NOP entry flagged on the extra if_exc output.
module inst_fetch_resp
   import inst_fetch_resp_pkg::*;
#(
   parameter int ADDR_W     = INST_ADDR_BUS,
   parameter int DATA_W     = INST_BUS,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc,
   input  logic              ce,
   input  logic              flush,
   input  logic              id_ready,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              if_valid,
   output logic [ADDR_W-1:0] if_pc,
   output logic [DATA_W-1:0] if_inst,
`ifdef FETCH_ALIGN_CHECK_EN
   output logic              if_exc,
`endif
   output logic              stallreq
);

`ifdef FETCH_ALIGN_CHECK_EN
   localparam int ENTRY_W = ADDR_W + DATA_W + 1;
`else
   localparam int ENTRY_W = ADDR_W + DATA_W;
`endif

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] tag_q, tag_d;

   logic               resp_valid;
   logic               pop;
   logic [2:0]         occ;
   logic               space_ok;
   logic               slot_free;
   logic               fetch_en;
   logic               misaligned;
   logic               exc_push;
   logic               fire;
   logic               push;
   logic [ENTRY_W-1:0] push_data;
   logic               fifo_full;
   logic               fifo_empty;
   logic [1:0]         fifo_count;
   logic [ENTRY_W-1:0] fifo_head;

   // Request/accept decisions. Outputs are forced low while rst is asserted
   // so the port reads idle immediately, not only after the next edge.
   always_comb begin
      resp_valid = mem_rvalid & (state_q == FETCH_WAIT);
      pop        = if_valid & id_ready;
      // Entries committed once this cycle's response and pop have settled;
      // a new request only goes out if its future entry has a slot.
      occ        = {1'b0, fifo_count} + {2'b00, resp_valid} - {2'b00, pop};
      space_ok   = (occ < 3'(FIFO_DEPTH));
      slot_free  = (state_q == FETCH_IDLE) | resp_valid;
      fetch_en   = rst & (ce == CHIP_ENABLE) & ~flush;
`ifdef FETCH_ALIGN_CHECK_EN
      misaligned = (pc[1:0] != 2'b00);
      // Only from IDLE, so the exception entry stays in order behind any
      // response still in flight and never collides with a memory push.
      exc_push   = fetch_en & misaligned & (state_q == FETCH_IDLE) & space_ok;
`else
      misaligned = 1'b0;
      exc_push   = 1'b0;
`endif
      mem_req    = fetch_en & ~misaligned & slot_free & space_ok;
      fire       = mem_req & mem_gnt;
      stallreq   = rst & (ce == CHIP_ENABLE) & ~(fire | exc_push);
      mem_addr   = rst ? pc : '0;
      push       = ~flush & (resp_valid | exc_push) & (~fifo_full | pop);
`ifdef FETCH_ALIGN_CHECK_EN
      push_data  = exc_push ? {pc, NOP_INST, 1'b1} : {tag_q, mem_rdata, 1'b0};
`else
      push_data  = {tag_q, mem_rdata};
`endif
   end

   // Next-state logic for the outstanding-request tracker.
   always_comb begin
      state_d = state_q;
      tag_d   = fire ? pc : tag_q;
      case (state_q)
         FETCH_IDLE: state_d = fire ? FETCH_WAIT : FETCH_IDLE;
         FETCH_WAIT: begin
            if (flush)           state_d = mem_rvalid ? FETCH_IDLE : FETCH_DROP;
            else if (mem_rvalid) state_d = fire ? FETCH_WAIT : FETCH_IDLE;
            else                 state_d = FETCH_WAIT;
         end
         FETCH_DROP: state_d = mem_rvalid ? FETCH_IDLE : FETCH_DROP;
         default:    state_d = FETCH_IDLE;
      endcase
   end

   // FSM state and captured request pc.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= FETCH_IDLE;
         tag_q   <= '0;
      end else begin
         state_q <= state_d;
         tag_q   <= tag_d;
      end
   end

   fetch_fifo #(
      .ENTRY_W(ENTRY_W)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_data(push_data),
      .pop      (pop),
      .clear    (flush),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count),
      .head     (fifo_head)
   );

   assign if_valid = ~fifo_empty;
   assign if_pc    = fifo_head[ENTRY_W-1 -: ADDR_W];
   assign if_inst  = fifo_head[ENTRY_W-ADDR_W-1 -: DATA_W];
`ifdef FETCH_ALIGN_CHECK_EN
   assign if_exc   = fifo_head[0];
`endif

endmodule
